// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, framebuffer geometry and phase-state type.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = 800;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = 525;

    localparam int unsigned FB_W        = 160;
    localparam int unsigned FB_H        = 120;
    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned ADDR_W      = 15;
    localparam int unsigned COLOUR_W    = 3;
    localparam int unsigned DAC_W       = 10;
    localparam int unsigned CNT_W       = 10;
    localparam int unsigned X_W         = 8;
    localparam int unsigned Y_W         = 7;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_e;

    // y*160 + x built from shifts: 160 = 128 + 32
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, horizontal/vertical counters with phase FSMs, raw sync/active and frame tick.
module vga_timing
    import vga_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    output logic             vga_clk,
    output logic             pixel_tick_c,
    output logic [CNT_W-1:0] h_nxt_c,
    output logic [CNT_W-1:0] v_nxt_c,
    output logic             active_nxt_c,
    output logic             hs_c,
    output logic             vs_c,
    output logic             active_c,
    output logic             frame_start
);

    logic             phase;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    phase_e           h_state;
    phase_e           h_state_nxt;
    phase_e           v_state;
    phase_e           v_state_nxt;
    logic             frame_start_nxt;
    logic             h_wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase       <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_state     <= ACTIVE;
            v_state     <= ACTIVE;
            frame_start <= 1'b0;
        end else begin
            phase       <= ~phase;
            h_cnt       <= h_nxt_c;
            v_cnt       <= v_nxt_c;
            h_state     <= h_state_nxt;
            v_state     <= v_state_nxt;
            frame_start <= frame_start_nxt;
        end
    end

    // Counters and phases only move on the pixel tick; vertical moves on the horizontal wrap
    always_comb begin
        h_nxt_c         = h_cnt;
        v_nxt_c         = v_cnt;
        h_state_nxt     = h_state;
        v_state_nxt     = v_state;
        frame_start_nxt = 1'b0;
        h_wrap          = 1'b0;
        if (pixel_tick_c) begin
            h_wrap  = (h_cnt == CNT_W'(H_TOTAL - 1));
            h_nxt_c = h_wrap ? '0 : h_cnt + 1'b1;
            case (h_state)
                ACTIVE:  if (h_cnt == CNT_W'(H_ACTIVE - 1)) h_state_nxt = FRONT;
                FRONT:   if (h_cnt == CNT_W'(H_ACTIVE + H_FP - 1)) h_state_nxt = SYNC;
                SYNC:    if (h_cnt == CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1)) h_state_nxt = BACK;
                BACK:    if (h_wrap) h_state_nxt = ACTIVE;
                default: h_state_nxt = ACTIVE;
            endcase
            if (h_wrap) begin
                v_nxt_c         = (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
                frame_start_nxt = (v_cnt == CNT_W'(V_ACTIVE - 1));
                case (v_state)
                    ACTIVE:  if (v_cnt == CNT_W'(V_ACTIVE - 1)) v_state_nxt = FRONT;
                    FRONT:   if (v_cnt == CNT_W'(V_ACTIVE + V_FP - 1)) v_state_nxt = SYNC;
                    SYNC:    if (v_cnt == CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1)) v_state_nxt = BACK;
                    BACK:    if (v_cnt == CNT_W'(V_TOTAL - 1)) v_state_nxt = ACTIVE;
                    default: v_state_nxt = ACTIVE;
                endcase
            end
        end
    end

    assign vga_clk      = phase;
    assign pixel_tick_c = phase;
    assign hs_c         = (h_state != SYNC);
    assign vs_c         = (v_state != SYNC);
    assign active_c     = (h_state == ACTIVE) && (v_state == ACTIVE);
    assign active_nxt_c = (h_state_nxt == ACTIVE) && (v_state_nxt == ACTIVE);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: raster address generation, RAM-latency stage and DAC colour expansion.
// Optional VGA_SCANOUT_TEST_PATTERN_EN adds test_mode for vertical colour bars.
module vga_scanout
    import vga_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [COLOUR_W-1:0] rd_data,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic                test_mode,
`endif
    output logic                frame_start,
    output logic                VGA_CLK,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic                VGA_BLANK_N,
    output logic                VGA_SYNC_N,
    output logic [DAC_W-1:0]    VGA_R,
    output logic [DAC_W-1:0]    VGA_G,
    output logic [DAC_W-1:0]    VGA_B
);

    logic             pixel_tick;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             active_nxt;
    logic             hs_raw;
    logic             vs_raw;
    logic             active_raw;
    logic [COLOUR_W-1:0] colour_c;

    vga_timing u_timing (
        .clock        (clock),
        .reset        (reset),
        .vga_clk      (VGA_CLK),
        .pixel_tick_c (pixel_tick),
        .h_nxt_c      (h_nxt),
        .v_nxt_c      (v_nxt),
        .active_nxt_c (active_nxt),
        .hs_c         (hs_raw),
        .vs_c         (vs_raw),
        .active_c     (active_raw),
        .frame_start  (frame_start)
    );

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [COLOUR_W-1:0] bar_q;

    // Bar colour is x[7:5] of the pixel whose address is being issued
    always_ff @(posedge clock) begin
        if (reset) begin
            bar_q <= '0;
        end else if (pixel_tick && active_nxt) begin
            bar_q <= h_nxt[CNT_W-1 -: COLOUR_W];
        end
    end

    assign colour_c = test_mode ? bar_q : rd_data;
`else
    assign colour_c = rd_data;
`endif

    // Address issued as counters step to (h,v); pins for (h,v) land one tick later
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_addr     <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pixel_tick) begin
            if (active_nxt) begin
                rd_addr <= fb_addr(X_W'(h_nxt >> SCALE_SHIFT), Y_W'(v_nxt >> SCALE_SHIFT));
            end
            VGA_HS      <= hs_raw;
            VGA_VS      <= vs_raw;
            VGA_BLANK_N <= active_raw;
            VGA_R       <= {DAC_W{active_raw & colour_c[2]}};
            VGA_G       <= {DAC_W{active_raw & colour_c[1]}};
            VGA_B       <= {DAC_W{active_raw & colour_c[0]}};
        end
    end

    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: pixel-index reference model plus targeted timing/latency checks.
module tb_vga_scanout;

    logic        clock = 1'b0;
    logic        reset;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;
    logic        tm;
    logic        frame_start;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [9:0]  VGA_R, VGA_G, VGA_B;

    logic [2:0]  fb [0:19199];

    int          tests_run;
    int          tests_failed;
    int          n;
    logic [14:0] exp_addr;
    logic        track_hs;
    logic        prev_hs;
    int          hs_fall[$];
    int          hs_rise[$];

    vga_scanout dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_mode   (tm),
`endif
        .frame_start (frame_start),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B)
    );

    always #10 clock = ~clock;

    // Synchronous-read framebuffer port
    always @(posedge clock) rd_data <= fb[rd_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s at t=%0t n=%0d: got %0h expected %0h", tag, $time, n, obs, exp);
        end
    endtask

    function automatic logic [35:0] pins_now();
        return {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_start, VGA_R, VGA_G, VGA_B};
    endfunction

    // Pins after k clocks out of reset show screen pixel k/2-1 of the raster sequence
    function automatic logic [35:0] exp_pins(input int k);
        int p, h, v, q;
        logic act, hs, vs, fs;
        logic [2:0] c;
        if (k < 2) return {1'(k % 2), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0};
        p   = k / 2 - 1;
        h   = p % 800;
        v   = (p / 800) % 525;
        act = (h < 640) && (v < 480);
        c   = 3'b000;
        if (act) c = tm ? 3'(h / 128) : fb[(v / 4) * 160 + h / 4];
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= 490 && v < 492);
        q   = k / 2;
        fs  = (k % 2 == 0) && (q % 800 == 0) && ((q / 800) % 525 == 480);
        return {1'(k % 2), hs, vs, act, 1'b0, fs, {10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    task automatic run_clk();
        int q, hq, vq;
        @(posedge clock);
        if (reset) n = 0;
        else n++;
        @(negedge clock);
        check("pins", 64'(pins_now()), 64'(exp_pins(n)));
        q  = n / 2;
        hq = q % 800;
        vq = (q / 800) % 525;
        if (hq < 640 && vq < 480) exp_addr = 15'((vq / 4) * 160 + hq / 4);
        check("rd_addr", 64'(rd_addr), 64'(exp_addr));
        if (track_hs && !reset) begin
            if (prev_hs && !VGA_HS) hs_fall.push_back(n);
            if (!prev_hs && VGA_HS) hs_rise.push_back(n);
        end
        prev_hs = VGA_HS;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 19200; i++) fb[i] = 3'($urandom);
    endtask

    initial begin
        reset        = 1'b1;
        tm           = 1'b0;
        tests_run    = 0;
        tests_failed = 0;
        n            = 0;
        exp_addr     = '0;
        track_hs     = 1'b0;
        prev_hs      = 1'b1;
        for (int i = 0; i < 19200; i++) fb[i] = 3'(i);

        repeat (3) run_clk();
        check("rst_pins", 64'(pins_now()), 64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0}));
        check("rst_addr", 64'(rd_addr), 64'd0);

        // Address-pattern RAM: pixel (8,4) -> addr 162 -> colour 2, replicated over h=8..11
        reset    = 1'b0;
        track_hs = 1'b1;
        repeat (6418) run_clk();
        check("px_8_4", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'h000, 10'h3FF, 10'h000}));
        for (int k = 1; k <= 3; k++) begin
            repeat (2) run_clk();
            check("px_rep", 64'({VGA_R[0], VGA_G[0], VGA_B[0], VGA_BLANK_N}), 64'(4'b0101));
        end
        track_hs = 1'b0;
        check("hs_fall_cnt", 64'(hs_fall.size()), 64'd4);
        check("hs_rise_cnt", 64'(hs_rise.size()), 64'd4);
        if (hs_fall.size() > 0) check("hs_first_fall", 64'(hs_fall[0]), 64'd1314);
        for (int i = 1; i < hs_fall.size(); i++)
            check("hs_period", 64'(hs_fall[i] - hs_fall[i-1]), 64'd1600);
        for (int i = 0; i < hs_rise.size() && i < hs_fall.size(); i++)
            check("hs_low", 64'(hs_rise[i] - hs_fall[i]), 64'd192);

        // Random RAM contents with a mid-frame reset
        reset = 1'b1;
        repeat (2) run_clk();
        fill_random();
        reset = 1'b0;
        repeat (4800 + $urandom_range(0, 1599)) run_clk();
        reset = 1'b1;
        repeat (3) run_clk();
        check("mid_rst_pins", 64'(pins_now()), 64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0}));
        check("mid_rst_addr", 64'(rd_addr), 64'd0);
        reset = 1'b0;
        repeat (2) run_clk();
        check("restart_addr", 64'(rd_addr), 64'd0);
        check("restart_px", 64'({VGA_BLANK_N, VGA_R[0], VGA_G[0], VGA_B[0]}), 64'({1'b1, fb[0]}));
        repeat (3200) run_clk();

        // All-white RAM: colours must still be zero in blanking
        reset = 1'b1;
        repeat (2) run_clk();
        for (int i = 0; i < 19200; i++) fb[i] = 3'b111;
        reset = 1'b0;
        repeat (202) run_clk();
        check("white_h100", 64'({VGA_BLANK_N, VGA_R, VGA_G, VGA_B}), 64'({1'b1, 30'h3FFF_FFFF}));
        repeat (1200) run_clk();
        check("blank_h700", 64'({VGA_BLANK_N, VGA_R, VGA_G, VGA_B}), 64'd0);
        repeat (1600) run_clk();

        // Latency: only address 0 is red
        reset = 1'b1;
        repeat (2) run_clk();
        for (int i = 0; i < 19200; i++) fb[i] = 3'b000;
        fb[0] = 3'b100;
        reset = 1'b0;
        run_clk();
        check("lat_early", 64'({VGA_BLANK_N, VGA_R}), 64'd0);
        run_clk();
        check("lat_r", 64'({VGA_BLANK_N, VGA_R}), 64'({1'b1, 10'h3FF}));
        repeat (40) run_clk();

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        reset = 1'b1;
        repeat (2) run_clk();
        fill_random();
        tm    = 1'b1;
        reset = 1'b0;
        repeat (262) run_clk();
        check("bar1", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'h000, 10'h000, 10'h3FF}));
        repeat (940) run_clk();
        check("bar4", 64'({VGA_R, VGA_G, VGA_B}), 64'({10'h3FF, 10'h000, 10'h000}));
        repeat (500) run_clk();
        tm = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
